// File: rtl/actor_pkg.sv
// Shared motion-state and velocity types for the actor, bomb and turn controller.
package actor_pkg;

  localparam int VEL_BITS = 5;

  typedef logic signed [VEL_BITS-1:0] vel_t;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    AIRBORNE = 2'd1,
    KNOCKED  = 2'd2
  } motion_t;

endpackage

// File: rtl/sat_add.sv
// Signed add of two velocities, clamped to +/-V_MAX.
module sat_add #(
  parameter int VEL_W = 5,
  parameter int V_MAX = 7
) (
  input  logic signed [VEL_W-1:0] i_a,
  input  logic signed [VEL_W-1:0] i_b,
  output logic signed [VEL_W-1:0] o_sum
);

  localparam logic signed [VEL_W:0] W_MAX = (VEL_W+1)'(V_MAX);
  localparam logic signed [VEL_W:0] W_MIN = (VEL_W+1)'(-V_MAX);

  logic signed [VEL_W:0] w_full;

  assign w_full = {i_a[VEL_W-1], i_a} + {i_b[VEL_W-1], i_b};

  always_comb begin
    o_sum = w_full[VEL_W-1:0];
    if (w_full > W_MAX)
      o_sum = W_MAX[VEL_W-1:0];
    else if (w_full < W_MIN)
      o_sum = W_MIN[VEL_W-1:0];
  end

endmodule

// File: rtl/actor_motion.sv
// Per-actor kinematics: position, velocity, facing and motion state, advanced on frame_tick.
module actor_motion
  import actor_pkg::*;
#(
  parameter int POS_W    = 10,
  parameter int VEL_W    = 5,
  parameter int X_MIN    = 5,
  parameter int X_MAX    = 634,
  parameter int Y_MIN    = 5,
  parameter int Y_MAX    = 474,
  parameter int X_START  = 320,
  parameter int Y_START  = 200,
  parameter int V_MAX    = 7,
  parameter int GRAV_DIV = 6,
  parameter int MOVE_DIV = 6,
  parameter int JUMP_DIV = 32,
  parameter int JUMP_V   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    active,
  input  logic                    key_left,
  input  logic                    key_right,
  input  logic                    key_jump,
  input  logic                    hit_down,
  input  logic                    hit_up,
  input  logic                    hit_left,
  input  logic                    hit_right,
  input  logic                    knock_valid,
  input  logic signed [VEL_W-1:0] knock_vx,
  input  logic signed [VEL_W-1:0] knock_vy,
  output logic [POS_W-1:0]        pos_x,
  output logic [POS_W-1:0]        pos_y,
  output logic signed [VEL_W-1:0] vel_x,
  output logic signed [VEL_W-1:0] vel_y,
  output logic                    facing,
  output motion_t                 state
);

  localparam int GW = $clog2(GRAV_DIV + 1);
  localparam int MW = $clog2(MOVE_DIV + 1);
  localparam int JW = $clog2(JUMP_DIV + 1);
  localparam int PW = POS_W + 2;
  localparam logic signed [VEL_W-1:0] V_ONE  = VEL_W'(1);
  localparam logic signed [VEL_W-1:0] V_NEG1 = '1;
  localparam logic signed [VEL_W-1:0] V_JUMP = VEL_W'(-JUMP_V);

  logic [POS_W-1:0]        r_px, r_py;
  logic signed [VEL_W-1:0] r_vx, r_vy;
  logic                    r_face;
  motion_t                 r_state;
  logic [GW-1:0]           r_grav;
  logic [MW-1:0]           r_move;
  logic [JW-1:0]           r_jump;
  logic                    r_kpend;
  logic signed [VEL_W-1:0] r_kvx, r_kvy;

  logic signed [VEL_W-1:0] w_kx_base, w_ky_base, w_kx_sum, w_ky_sum;
  logic signed [VEL_W-1:0] w_vy_grav, w_step_b, w_vx_step;
  logic signed [VEL_W-1:0] w_vx, w_vy, w_vx_sat, w_vy_sat, w_vx_n, w_vy_n;
  logic [MW-1:0]           w_move_inc, w_move;
  logic [JW-1:0]           w_jump_inc, w_jump;
  logic [GW-1:0]           w_grav;
  logic                    w_face, w_emb;
  motion_t                 w_st, w_st_n;
  logic signed [PW-1:0]    w_nx, w_ny;
  logic [POS_W-1:0]        w_px_n, w_py_n;

  // A knock arriving with frame_tick starts a fresh pending impulse for the next tick.
  assign w_kx_base = frame_tick ? '0 : r_kvx;
  assign w_ky_base = frame_tick ? '0 : r_kvy;
  assign w_step_b  = key_left ? V_NEG1 : V_ONE;

  sat_add #(.VEL_W(VEL_W), .V_MAX(V_MAX)) u_knock_x (.i_a(w_kx_base), .i_b(knock_vx), .o_sum(w_kx_sum));
  sat_add #(.VEL_W(VEL_W), .V_MAX(V_MAX)) u_knock_y (.i_a(w_ky_base), .i_b(knock_vy), .o_sum(w_ky_sum));
  sat_add #(.VEL_W(VEL_W), .V_MAX(V_MAX)) u_grav    (.i_a(r_vy),      .i_b(V_ONE),    .o_sum(w_vy_grav));
  sat_add #(.VEL_W(VEL_W), .V_MAX(V_MAX)) u_step    (.i_a(r_vx),      .i_b(w_step_b), .o_sum(w_vx_step));
  sat_add #(.VEL_W(VEL_W), .V_MAX(V_MAX)) u_sat_x   (.i_a(w_vx),      .i_b('0),       .o_sum(w_vx_sat));
  sat_add #(.VEL_W(VEL_W), .V_MAX(V_MAX)) u_sat_y   (.i_a(w_vy),      .i_b('0),       .o_sum(w_vy_sat));

  assign w_move_inc = (r_move == MW'(MOVE_DIV)) ? r_move : r_move + MW'(1);
  assign w_jump_inc = (r_jump == JW'(JUMP_DIV)) ? r_jump : r_jump + JW'(1);

  always_comb begin
    w_vx   = r_vx;
    w_vy   = r_vy;
    w_st   = r_state;
    w_face = r_face;
    w_grav = r_grav;
    w_move = w_move_inc;
    w_jump = w_jump_inc;
    w_emb  = 1'b0;
    if (r_kpend) begin
      w_vx = r_kvx;
      w_vy = r_kvy;
      w_st = KNOCKED;
    end else begin
      if (r_state != GROUNDED) begin
        if (r_grav == GW'(GRAV_DIV - 1)) begin
          w_vy   = w_vy_grav;
          w_grav = '0;
        end else begin
          w_grav = r_grav + GW'(1);
        end
      end else begin
        w_grav = '0;
      end
      if (active && r_state != KNOCKED) begin
        if (w_move_inc == MW'(MOVE_DIV) && (key_left ^ key_right)) begin
          w_vx   = w_vx_step;
          w_face = key_left;
          w_move = '0;
        end
        if (r_state == GROUNDED && !key_left && !key_right)
          w_vx = '0;
        if (r_state == GROUNDED && key_jump && w_jump_inc == JW'(JUMP_DIV)) begin
          w_vy   = V_JUMP;
          w_st   = AIRBORNE;
          w_jump = '0;
        end
      end
    end
    if ((hit_left && w_vx < 0) || (hit_right && w_vx > 0))
      w_vx = '0;
    if (hit_up && w_vy < 0)
      w_vy = '0;
    if (hit_down && w_vy >= 0) begin
      w_vy = '0;
      w_st = GROUNDED;
    end
    if (hit_down && hit_up) begin
      w_vy  = '0;
      w_emb = 1'b1;
    end
    if (!hit_down && w_st == GROUNDED)
      w_st = AIRBORNE;
  end

  // Position integrates the velocity held before this tick; the new velocity moves it next tick.
  assign w_nx = PW'({2'b00, r_px}) + PW'(r_vx);
  assign w_ny = PW'({2'b00, r_py}) + PW'(r_vy) - PW'({1'b0, w_emb});

  always_comb begin
    w_px_n = w_nx[POS_W-1:0];
    w_py_n = w_ny[POS_W-1:0];
    w_vx_n = w_vx_sat;
    w_vy_n = w_vy_sat;
    w_st_n = w_st;
    if (w_nx < PW'(X_MIN)) begin
      w_px_n = POS_W'(X_MIN);
      w_vx_n = V_ONE;
    end else if (w_nx > PW'(X_MAX)) begin
      w_px_n = POS_W'(X_MAX);
      w_vx_n = V_NEG1;
    end
    if (w_ny < PW'(Y_MIN)) begin
      w_py_n = POS_W'(Y_MIN);
      w_vy_n = V_ONE;
    end else if (w_ny > PW'(Y_MAX)) begin
      w_py_n = POS_W'(Y_MAX);
      w_vy_n = V_NEG1;
      w_st_n = GROUNDED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_px    <= POS_W'(X_START);
      r_py    <= POS_W'(Y_START);
      r_vx    <= '0;
      r_vy    <= '0;
      r_face  <= 1'b0;
      r_state <= AIRBORNE;
      r_grav  <= '0;
      r_move  <= '0;
      r_jump  <= '0;
      r_kpend <= 1'b0;
      r_kvx   <= '0;
      r_kvy   <= '0;
    end else begin
      if (frame_tick) begin
        r_px    <= w_px_n;
        r_py    <= w_py_n;
        r_vx    <= w_vx_n;
        r_vy    <= w_vy_n;
        r_face  <= w_face;
        r_state <= w_st_n;
        r_grav  <= w_grav;
        r_move  <= w_move;
        r_jump  <= w_jump;
      end
      if (knock_valid) begin
        r_kpend <= 1'b1;
        r_kvx   <= w_kx_sum;
        r_kvy   <= w_ky_sum;
      end else if (frame_tick) begin
        r_kpend <= 1'b0;
        r_kvx   <= '0;
        r_kvy   <= '0;
      end
    end
  end

  assign pos_x = r_px;
  assign pos_y = r_py;
  assign vel_x = r_vx;
  assign vel_y = r_vy;
  assign facing = r_face;
  assign state = r_state;

endmodule

// File: tb/tb_actor_motion.sv
// Scoreboard bench for actor_motion: directed frames with hand-derived expected outputs.
module tb_actor_motion;
  import actor_pkg::*;

  localparam int DC = -9999;
  localparam int G  = 0;
  localparam int A  = 1;
  localparam int K  = 2;

  logic clk = 1'b0;
  logic reset, frame_tick, active, key_left, key_right, key_jump;
  logic hit_down, hit_up, hit_left, hit_right, knock_valid;
  logic signed [4:0] knock_vx, knock_vy, vel_x, vel_y;
  logic [9:0] pos_x, pos_y;
  logic facing;
  motion_t state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int px, py, vx, vy, fc, st;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  actor_motion #(.POS_W(10), .VEL_W(5), .V_MAX(7)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .active(active),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .hit_down(hit_down), .hit_up(hit_up), .hit_left(hit_left), .hit_right(hit_right),
    .knock_valid(knock_valid), .knock_vx(knock_vx), .knock_vy(knock_vy),
    .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
    .facing(facing), .state(state)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int px, input int py, input int vx,
                            input int vy, input int fc, input int st);
    exp_t e;
    e.tag = tag; e.px = px; e.py = py; e.vx = vx; e.vy = vy; e.fc = fc; e.st = st;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (e.px != DC) check_val({e.tag, ".pos_x"}, int'(pos_x), e.px);
    if (e.py != DC) check_val({e.tag, ".pos_y"}, int'(pos_y), e.py);
    if (e.vx != DC) check_val({e.tag, ".vel_x"}, int'(vel_x), e.vx);
    if (e.vy != DC) check_val({e.tag, ".vel_y"}, int'(vel_y), e.vy);
    if (e.fc != DC) check_val({e.tag, ".facing"}, int'(facing), e.fc);
    if (e.st != DC) check_val({e.tag, ".state"}, int'(state), e.st);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic step(input string tag, input int px, input int py, input int vx,
                      input int vy, input int fc, input int st);
    expect_out(tag, px, py, vx, vy, fc, st);
    tick();
    compare_out();
  endtask

  task automatic knock(input int vx, input int vy);
    @(negedge clk);
    knock_valid = 1'b1;
    knock_vx = 5'(vx);
    knock_vy = 5'(vy);
    @(negedge clk);
    knock_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 0; active = 0; key_left = 0; key_right = 0; key_jump = 0;
    hit_down = 0; hit_up = 0; hit_left = 0; hit_right = 0;
    knock_valid = 0; knock_vx = '0; knock_vy = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int px, vx;

    // Reset state and gravity cadence
    do_reset();
    expect_out("reset", 320, 200, 0, 0, 0, A);
    compare_out();
    for (int i = 1; i <= 5; i++) step($sformatf("grav%0d", i), 320, 200, 0, 0, 0, A);
    step("grav6", 320, 200, 0, 1, 0, A);
    step("grav7", 320, 201, 0, 1, 0, A);

    // Horizontal key stepping and saturation
    do_reset();
    hit_down = 1;
    step("land", 320, 200, 0, 0, 0, G);
    for (int i = 0; i < 6; i++) step("idle", 320, 200, 0, 0, 0, G);
    active = 1; key_right = 1;
    px = 320; vx = 0;
    for (int n = 0; n < 44; n++) begin
      int nvx;
      nvx = 1 + n / 6;
      if (nvx > 7) nvx = 7;
      px = px + vx;
      vx = nvx;
      step($sformatf("move%0d", n), px, 200, vx, 0, 0, G);
    end
    key_right = 0;
    for (int i = 0; i < 7; i++) step("release", DC, 200, 0, 0, 0, G);
    key_left = 1;
    step("left", DC, 200, -1, 0, 1, G);
    key_left = 0;
    step("stop", DC, 200, 0, 0, 1, G);

    // Jump gating by active and jump interval
    active = 0; key_jump = 1;
    step("nojump", DC, 200, 0, 0, 1, G);
    active = 1;
    step("jump", DC, 200, 0, -4, 1, A);
    hit_up = 1;
    step("reland", DC, 195, 0, 0, 1, G);
    hit_up = 0;
    for (int k = 2; k <= 31; k++) step($sformatf("wait%0d", k), DC, 195, 0, 0, 1, G);
    step("rejump", DC, 195, 0, -4, 1, A);

    // Knock accumulation with saturation, keys ignored while knocked
    do_reset();
    knock(5, -3);
    knock(5, -3);
    step("knock", 320, 200, 7, -6, 0, K);
    active = 1; key_left = 1;
    step("kn1", 327, 194, 7, -6, 0, K);
    step("kn2", 334, 188, 7, -6, 0, K);
    step("kn3", 341, 182, 7, -6, 0, K);
    hit_down = 1;
    step("kn_rise", 348, 176, 7, -6, 0, K);
    hit_up = 1;
    step("kn_land", 355, 169, 7, 0, 0, G);
    hit_up = 0;
    step("kn_key", 362, 169, 6, 0, 1, G);

    // Right clamp with bounce
    do_reset();
    knock(7, 0);
    step("rk", 320, 200, 7, 0, 0, K);
    for (int n = 1; n <= 46; n++) begin
      int ex, ev;
      if (n <= 44) begin ex = 320 + 7 * n; ev = 7; end
      else if (n == 45) begin ex = 634; ev = -1; end
      else begin ex = 633; ev = -1; end
      step($sformatf("xr%0d", n), ex, DC, ev, DC, 0, K);
    end

    // Left clamp: landing exactly on X_MIN does not bounce
    do_reset();
    knock(-7, 0);
    step("lk", 320, 200, -7, 0, 0, K);
    for (int n = 1; n <= 47; n++) begin
      int ex, ev;
      if (n <= 45) begin ex = 320 - 7 * n; ev = -7; end
      else if (n == 46) begin ex = 5; ev = 1; end
      else begin ex = 6; ev = 1; end
      step($sformatf("xl%0d", n), ex, DC, ev, DC, 0, K);
    end

    // Embedded contacts, then a knock coinciding with frame_tick
    do_reset();
    hit_down = 1; hit_up = 1;
    step("emb1", 320, 199, 0, 0, 0, G);
    step("emb2", 320, 198, 0, 0, 0, G);
    step("emb3", 320, 197, 0, 0, 0, G);
    hit_up = 0;
    expect_out("knock_on_tick", 320, 197, 0, 0, 0, G);
    @(negedge clk);
    frame_tick = 1; knock_valid = 1; knock_vx = 5'sd3; knock_vy = 5'sd2;
    @(negedge clk);
    frame_tick = 0; knock_valid = 0;
    compare_out();
    hit_down = 0;
    step("knock_held", 320, 197, 3, 2, 0, K);
    step("knock_after", 323, 199, 3, 2, 0, K);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 reset = 1;
    #1;
    expect_out("async_reset", 320, 200, 0, 0, 0, A);
    compare_out();
    @(negedge clk);
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
